// File: rtl/leaf_pkt_pkg.sv
// Shared definitions for the BFT leaf packet transmitter.
//   - Field offsets of the default 49-bit packet layout
//     ([48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload)
//   - CTRL_PORT: port number that marks a credit-return packet
//   - state_t:   transmit FSM states
//   - packet_t:  packed view of a default-width packet
package leaf_pkt_pkg;

  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB    = 32;
  localparam int PORT_LSB    = 39;
  localparam int LEAF_LSB    = 43;
  localparam int VALID_BIT   = 48;

  localparam int CTRL_PORT   = 0;

  // IDLE: output register empty; SEND: packet presented; HOLD: packet rejected
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  leaf;
    logic [3:0]  port;
    logic [6:0]  addr;
    logic [31:0] payload;
  } packet_t;

endpackage

// File: rtl/leaf_credit_counter.sv
// Credit counter for the leaf transmitter.
// Adds FREESPACE_UPDATE_SIZE on a credit return, subtracts one per transfer,
// and saturates at 2^NUM_ADDR_BITS (excess returned credit is dropped).
// Ports:
//   clk, reset : clock, synchronous active-high reset (credit -> max)
//   ret        : credit-return packet seen this cycle
//   take       : user word transferred this cycle (only when credit > 0)
//   credit     : current credit, NUM_ADDR_BITS+1 bits
module leaf_credit_counter #(
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ret,
  input  logic                   take,
  output logic [NUM_ADDR_BITS:0] credit
);

  localparam int CW = NUM_ADDR_BITS + 1;
  localparam logic [31:0] MAX = 32'(1) << NUM_ADDR_BITS;

  logic [31:0]   sum;
  logic [CW-1:0] credit_nxt;

  // 32-bit intermediate avoids overflow before the saturation compare.
  always_comb begin
    sum = 32'(credit) + (ret ? 32'(FREESPACE_UPDATE_SIZE) : 32'd0)
                      - (take ? 32'd1 : 32'd0);
    credit_nxt = (sum > MAX) ? CW'(MAX) : CW'(sum);
  end

  always_ff @(posedge clk) begin
    if (reset) credit <= CW'(MAX);
    else       credit <= credit_nxt;
  end

endmodule

// File: rtl/leaf_packet_tx.sv
// Leaf packet transmitter: wraps user words into BFT packets with
// credit-based flow control and resend (reject) handling.
// Optional macro LEAF_PACKET_TX_STATS_EN adds delivery/resend counters.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   din_leaf_user2interface   : user data word
//   vld_user2interface        : user word valid
//   ack_interface2user        : word accepted this cycle (when vld is high)
//   dout_leaf_interface2bft   : packet to the BFT (0 when nothing presented)
//   din_leaf_bft2interface    : packets from the BFT; port 0 = credit return
//   resend                    : BFT rejects this cycle's packet
//   pkt_sent_cnt, resend_cnt  : (stats build only) delivered / rejected counts
module leaf_packet_tx
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int DEST_LEAF             = 0,
  parameter int DEST_PORT             = 1,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic                    vld_user2interface,
  output logic                    ack_interface2user,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
  input  logic                    resend
`ifdef LEAF_PACKET_TX_STATS_EN
  ,
  output logic [31:0]             pkt_sent_cnt,
  output logic [31:0]             resend_cnt
`endif
);

  localparam int VLD_POS  = PACKET_BITS - 1;
  localparam int PORT_POS = PAYLOAD_BITS + NUM_ADDR_BITS;

  state_t                   state, state_nxt;
  logic [PACKET_BITS-1:0]   pkt_q;
  logic [NUM_ADDR_BITS-1:0] wr_ptr;
  logic [NUM_ADDR_BITS:0]   credit;
  logic                     started;
  logic                     xfer, delivered, credit_ret;

  // Only valid and port are needed from incoming packets.
  logic unused_din_bits;
  assign unused_din_bits = ^din_leaf_bft2interface;

  assign credit_ret = din_leaf_bft2interface[VLD_POS] &&
    (din_leaf_bft2interface[PORT_POS +: NUM_PORT_BITS] == NUM_PORT_BITS'(CTRL_PORT));

  always_comb begin
    state_nxt = state;
    delivered = (state == SEND) && !resend;
    // started keeps ack low in the first cycle after reset release.
    ack_interface2user = started && (credit != '0) &&
                         ((state == IDLE) || delivered);
    xfer = vld_user2interface && ack_interface2user;
    dout_leaf_interface2bft = delivered ? pkt_q : '0;
    case (state)
      IDLE:    if (xfer) state_nxt = SEND;
      SEND:    if (resend) state_nxt = HOLD;
               else if (!xfer) state_nxt = IDLE;
      HOLD:    if (!resend) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pkt_q   <= '0;
      wr_ptr  <= '0;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (xfer) begin
        pkt_q  <= {1'b1, NUM_LEAF_BITS'(DEST_LEAF), NUM_PORT_BITS'(DEST_PORT),
                   wr_ptr, din_leaf_user2interface};
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  leaf_credit_counter #(
    .NUM_ADDR_BITS        (NUM_ADDR_BITS),
    .FREESPACE_UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .ret   (credit_ret),
    .take  (xfer),
    .credit(credit)
  );

`ifdef LEAF_PACKET_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_sent_cnt <= '0;
      resend_cnt   <= '0;
    end else begin
      if (delivered)                 pkt_sent_cnt <= pkt_sent_cnt + 1'b1;
      if ((state == SEND) && resend) resend_cnt   <= resend_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_leaf_packet_tx.sv
// Directed testbench for leaf_packet_tx (default parameters).
module tb_leaf_packet_tx;
  import leaf_pkt_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din_user;
  logic        vld;
  logic        ack;
  logic [48:0] dout;
  logic [48:0] din_bft;
  logic        resend;
`ifdef LEAF_PACKET_TX_STATS_EN
  logic [31:0] pkt_sent_cnt, resend_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // credit return: valid=1, leaf=3, port=0
  localparam logic [48:0] CPKT = {1'b1, 5'd3, 4'd0, 7'd0, 32'd0};

  leaf_packet_tx dut (
    .clk                    (clk),
    .reset                  (reset),
    .din_leaf_user2interface(din_user),
    .vld_user2interface     (vld),
    .ack_interface2user     (ack),
    .dout_leaf_interface2bft(dout),
    .din_leaf_bft2interface (din_bft),
    .resend                 (resend)
`ifdef LEAF_PACKET_TX_STATS_EN
    ,
    .pkt_sent_cnt           (pkt_sent_cnt),
    .resend_cnt             (resend_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] exp_pkt(input logic [6:0] addr, input logic [31:0] pl);
    return {1'b1, 5'd0, 4'd1, addr, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; vld = 1'b0; resend = 1'b0; din_bft = '0; din_user = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if (dout !== 49'd0 || ack !== 1'b0 || dut.credit !== 8'd128 ||
        dut.wr_ptr !== 7'd0 || dut.state != IDLE) begin
      n_fail++;
      $display("FAIL reset_state: dout=%h ack=%b credit=%0d wr_ptr=%0d, want 0 0 128 0",
               dout, ack, dut.credit, dut.wr_ptr);
    end
    vld = 1'b1; din_user = 32'h1; #1;
    n_vec++;
    if (ack !== 1'b0) begin
      n_fail++; $display("FAIL ack_first_cycle: ack=%b want 0", ack);
    end
    tick();
    n_vec++;
    if (ack !== 1'b1) begin
      n_fail++; $display("FAIL ack_second_cycle: ack=%b want 1", ack);
    end
    vld = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(); tick();
    din_user = 32'hA; vld = 1'b1; #1;
    n_vec++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack: ack=%b want 1", ack); end
    tick(); din_user = 32'hB; #1;
    n_vec++;
    if (dout !== exp_pkt(7'd0, 32'hA)) begin
      n_fail++; $display("FAIL b2b_pkt0: dout=%h want %h", dout, exp_pkt(7'd0, 32'hA));
    end
    tick(); din_user = 32'hC; #1;
    n_vec++;
    if (dout !== exp_pkt(7'd1, 32'hB)) begin
      n_fail++; $display("FAIL b2b_pkt1: dout=%h want %h", dout, exp_pkt(7'd1, 32'hB));
    end
    tick(); vld = 1'b0; #1;
    n_vec++;
    if (dout !== exp_pkt(7'd2, 32'hC)) begin
      n_fail++; $display("FAIL b2b_pkt2: dout=%h want %h", dout, exp_pkt(7'd2, 32'hC));
    end
    n_vec++;
    if (dut.credit !== 8'd125 || dut.wr_ptr !== 7'd3) begin
      n_fail++; $display("FAIL b2b_credit: credit=%0d wr_ptr=%0d want 125 3",
                         dut.credit, dut.wr_ptr);
    end
    tick();
    n_vec++;
    if (dout !== 49'd0) begin n_fail++; $display("FAIL b2b_idle: dout=%h want 0", dout); end
  endtask

  task automatic test_wrap();
    int miss = 0;
    do_reset(); tick();
    vld = 1'b1;
    for (int i = 0; i < 128; i++) begin
      din_user = i; #1;
      if (ack !== 1'b1) miss++;
      tick();
    end
    n_vec++;
    if (miss != 0) begin n_fail++; $display("FAIL wrap_acks: missed=%0d want 0", miss); end
    #1;
    n_vec++;
    if (ack !== 1'b0 || dut.credit !== 8'd0 || dout !== exp_pkt(7'd127, 32'd127)) begin
      n_fail++; $display("FAIL wrap_exhaust: ack=%b credit=%0d dout=%h want 0 0 %h",
                         ack, dut.credit, dout, exp_pkt(7'd127, 32'd127));
    end
    tick(); tick(); #1;
    n_vec++;
    if (ack !== 1'b0 || dout !== 49'd0) begin
      n_fail++; $display("FAIL wrap_stall: ack=%b dout=%h want 0 0", ack, dout);
    end
    din_bft = CPKT; tick(); din_bft = '0; din_user = 32'h129; #1;
    n_vec++;
    if (ack !== 1'b1 || dut.credit !== 8'd64) begin
      n_fail++; $display("FAIL wrap_credit_ret: ack=%b credit=%0d want 1 64", ack, dut.credit);
    end
    tick(); vld = 1'b0; #1;
    n_vec++;
    if (dout !== exp_pkt(7'd0, 32'h129)) begin
      n_fail++; $display("FAIL wrap_pkt129: dout=%h want %h", dout, exp_pkt(7'd0, 32'h129));
    end
    tick();
  endtask

  task automatic test_resend();
    int seen = 0, bad = 0, ack_hi = 0;
    do_reset(); tick();
    vld = 1'b1;
    for (int i = 0; i < 5; i++) begin din_user = i; tick(); end
    din_user = 32'h55; tick(); vld = 1'b0;
    resend = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (dout !== 49'd0) bad++;
      if (ack !== 1'b0) ack_hi++;
      tick();
    end
    n_vec++;
    if (bad != 0 || ack_hi != 0) begin
      n_fail++; $display("FAIL resend_hold: nonzero_out=%0d ack_high=%0d want 0 0", bad, ack_hi);
    end
    resend = 1'b0; bad = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (dout === exp_pkt(7'd5, 32'h55)) seen++;
      else if (dout !== 49'd0) bad++;
      tick();
    end
    n_vec++;
    if (seen != 1 || bad != 0) begin
      n_fail++; $display("FAIL resend_replay: seen=%0d other=%0d want 1 0", seen, bad);
    end
  endtask

  task automatic test_credit_arith();
    do_reset(); tick();
    vld = 1'b1;
    for (int i = 0; i < 118; i++) begin din_user = i; tick(); end
    n_vec++;
    if (dut.credit !== 8'd10) begin
      n_fail++; $display("FAIL credit_at10: credit=%0d want 10", dut.credit);
    end
    din_bft = CPKT; din_user = 32'h77; tick(); vld = 1'b0; din_bft = '0;
    n_vec++;
    if (dut.credit !== 8'd73) begin
      n_fail++; $display("FAIL credit_ret_xfer: credit=%0d want 73", dut.credit);
    end
    do_reset(); tick();
    vld = 1'b1;
    for (int i = 0; i < 28; i++) begin din_user = i; tick(); end
    vld = 1'b0;
    din_bft = {1'b1, 5'd0, 4'd3, 7'd0, 32'd0}; tick();
    din_bft = {1'b0, 5'd0, 4'd0, 7'd0, 32'd0}; tick();
    n_vec++;
    if (dut.credit !== 8'd100) begin
      n_fail++; $display("FAIL credit_ignore: credit=%0d want 100", dut.credit);
    end
    din_bft = CPKT; tick();
    n_vec++;
    if (dut.credit !== 8'd128) begin
      n_fail++; $display("FAIL credit_sat1: credit=%0d want 128", dut.credit);
    end
    tick(); din_bft = '0;
    n_vec++;
    if (dut.credit !== 8'd128) begin
      n_fail++; $display("FAIL credit_sat2: credit=%0d want 128", dut.credit);
    end
  endtask

  task automatic test_reset_in_hold();
    int bad = 0;
    do_reset(); tick();
    vld = 1'b1; din_user = 32'hDEAD; tick(); vld = 1'b0;
    resend = 1'b1; tick();
    n_vec++;
    if (dut.state != HOLD) begin
      n_fail++; $display("FAIL rsthold_enter: state=%0d want %0d", dut.state, HOLD);
    end
    reset = 1'b1; tick(); reset = 1'b0; resend = 1'b0; #1;
    n_vec++;
    if (dout !== 49'd0 || dut.credit !== 8'd128 || dut.wr_ptr !== 7'd0 || dut.state != IDLE) begin
      n_fail++; $display("FAIL rsthold_state: dout=%h credit=%0d wr_ptr=%0d want 0 128 0",
                         dout, dut.credit, dut.wr_ptr);
    end
    for (int c = 0; c < 6; c++) begin
      if (dout !== 49'd0) bad++;
      tick();
    end
    n_vec++;
    if (bad != 0) begin n_fail++; $display("FAIL rsthold_no_replay: nonzero=%0d want 0", bad); end
  endtask

`ifdef LEAF_PACKET_TX_STATS_EN
  task automatic test_stats();
    do_reset(); tick();
    n_vec++;
    if (pkt_sent_cnt !== 32'd0 || resend_cnt !== 32'd0) begin
      n_fail++; $display("FAIL stats_reset: sent=%0d resend=%0d want 0 0", pkt_sent_cnt, resend_cnt);
    end
    vld = 1'b1; din_user = 32'd1; tick(); vld = 1'b0;
    resend = 1'b1; tick(); resend = 1'b0;
    tick(); tick(); tick();
    vld = 1'b1;
    for (int i = 2; i < 5; i++) begin din_user = i; tick(); end
    vld = 1'b0; tick(); tick();
    n_vec++;
    if (pkt_sent_cnt !== 32'd4 || resend_cnt !== 32'd1) begin
      n_fail++; $display("FAIL stats_counts: sent=%0d resend=%0d want 4 1", pkt_sent_cnt, resend_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_resend();
    test_credit_arith();
    test_reset_in_hold();
`ifdef LEAF_PACKET_TX_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
